// File: rtl/radio_mac_pkg.sv
// Shared types and constants for the radio MAC sequencer: state encoding,
// LFSR feedback taps and the backoff window mask helper.
package radio_mac_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SETTLE_RX = 3'd1,
      CCA       = 3'd2,
      BACKOFF   = 3'd3,
      SETTLE_TX = 3'd4,
      TX        = 3'd5,
      ACK_WAIT  = 3'd6
   } mac_state_e;

   // x^8+x^6+x^5+x^4+1 on a left-shifting register: feedback from bits 7,5,4,3
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   localparam int unsigned BACKOFF_EXP_CAP = 4;

   // Contention window mask (2 << min(retry+1, cap)) - 1
   function automatic logic [7:0] backoff_mask(input logic [2:0] retry);
      int unsigned e;
      e = 32'(retry) + 32'd1;
      if (e > BACKOFF_EXP_CAP) e = BACKOFF_EXP_CAP;
      return 8'((32'd2 << e) - 32'd1);
   endfunction

endpackage

// File: rtl/radio_mac_ctrl_if.sv
// Handshake bundle between the MAC sequencer (slave) and the CPU register
// bank / txrx datapath side (master).
interface radio_mac_if;
   logic       tx_req;
   logic       ack_req;
   logic       listen_en;
   logic       channel_busy;
   logic       tx_done;
   logic       ack_rcvd;
   logic       radio_rx_en;
   logic       radio_tx_en;
   logic       tx_start;
   logic       busy;
   logic       tx_ok;
   logic       tx_fail;
   logic [2:0] retry_cnt;

   modport master (
      output tx_req, ack_req, listen_en, channel_busy, tx_done, ack_rcvd,
      input  radio_rx_en, radio_tx_en, tx_start, busy, tx_ok, tx_fail, retry_cnt
   );

   modport slave (
      input  tx_req, ack_req, listen_en, channel_busy, tx_done, ack_rcvd,
      output radio_rx_en, radio_tx_en, tx_start, busy, tx_ok, tx_fail, retry_cnt
   );
endinterface

// File: rtl/mac_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR used to randomise backoff slot counts.
// A nonzero SEED keeps it off the all-zero lock-up state.
module mac_lfsr8
   import radio_mac_pkg::*;
#(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] value_o
);

   logic [7:0] lfsr_q;
   logic [7:0] lfsr_d;

   assign lfsr_d[0] = ^(lfsr_q & LFSR_TAPS);

   genvar gi;
   generate
      for (gi = 1; gi < 8; gi++) begin : g_shift
         assign lfsr_d[gi] = lfsr_q[gi-1];
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign value_o = lfsr_q;

endmodule

// File: rtl/radio_mac_ctrl.sv
// Medium-access sequencer: settle, CCA, random backoff, transmit, ack window
// with retries. Define MAC_STATS_EN to add the saturating statistics outputs.
module radio_mac_ctrl
   import radio_mac_pkg::*;
#(
   parameter logic [7:0]  SEED          = 8'hA5,
   parameter int unsigned SETTLE_CYCLES = 16,
   parameter int unsigned CCA_CYCLES    = 64,
   parameter int unsigned SLOT_CYCLES   = 32,
   parameter int unsigned MAX_RETRIES   = 3,
   parameter int unsigned ACK_CYCLES    = 4096
) (
   input  logic        clk,
   input  logic        reset,
   radio_mac_if.slave  bus
`ifdef MAC_STATS_EN
   ,
   output logic [15:0] stat_cca_busy,
   output logic [15:0] stat_tx_fail
`endif
);

   // One shared counter covers every timed state; longest backoff is 32 slots
   localparam int unsigned BO_MAX  = 32 * SLOT_CYCLES;
   localparam int unsigned MAX_A   = (SETTLE_CYCLES > CCA_CYCLES) ? SETTLE_CYCLES : CCA_CYCLES;
   localparam int unsigned MAX_B   = (BO_MAX > ACK_CYCLES) ? BO_MAX : ACK_CYCLES;
   localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CCA_LAST    = CNT_W'(CCA_CYCLES - 1);
   localparam logic [CNT_W-1:0] ACK_LAST    = CNT_W'(ACK_CYCLES - 1);
   localparam logic [2:0]       RETRY_LIMIT = 3'(MAX_RETRIES);

   logic [7:0] lfsr_val;

   mac_lfsr8 #(.SEED(SEED)) u_lfsr (
      .clk     (clk),
      .reset   (reset),
      .value_o (lfsr_val)
   );

   function automatic logic [CNT_W-1:0] backoff_len(input logic [7:0] lfsr,
                                                    input logic [2:0] retry);
      logic [8:0] slots;
      slots = {1'b0, lfsr & backoff_mask(retry)} + 9'd1;
      return CNT_W'(32'(slots) * SLOT_CYCLES);
   endfunction

   mac_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] bo_len_q, bo_len_d;
   logic [2:0]       retry_q, retry_d;
   logic             ack_mode_q, ack_mode_d;
   logic             done_ok, done_fail;

   logic             rx_en_q, tx_en_q, tx_start_q, busy_q, tx_ok_q, tx_fail_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bo_len_d   = bo_len_q;
      retry_d    = retry_q;
      ack_mode_d = ack_mode_q;
      done_ok    = 1'b0;
      done_fail  = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.tx_req) begin
               ack_mode_d = bus.ack_req;
               retry_d    = 3'd0;
               cnt_d      = '0;
               // An already-listening receiver needs no settle time
               state_d    = bus.listen_en ? CCA : SETTLE_RX;
            end
         end
         SETTLE_RX: begin
            if (cnt_q == SETTLE_LAST) begin
               state_d = CCA;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         CCA: begin
            if (bus.channel_busy) begin
               state_d  = BACKOFF;
               cnt_d    = '0;
               bo_len_d = backoff_len(lfsr_val, retry_q);
            end else if (cnt_q == CCA_LAST) begin
               state_d = SETTLE_TX;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         BACKOFF: begin
            if (cnt_q == bo_len_q - 1'b1) begin
               state_d = CCA;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SETTLE_TX: begin
            if (cnt_q == SETTLE_LAST) begin
               state_d = TX;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         TX: begin
            if (bus.tx_done) begin
               cnt_d = '0;
               if (ack_mode_q) begin
                  state_d = ACK_WAIT;
               end else begin
                  state_d = IDLE;
                  done_ok = 1'b1;
               end
            end
         end
         ACK_WAIT: begin
            // An ack landing on the timeout cycle still wins
            if (bus.ack_rcvd) begin
               state_d = IDLE;
               done_ok = 1'b1;
            end else if (cnt_q == ACK_LAST) begin
               cnt_d = '0;
               if (retry_q < RETRY_LIMIT) begin
                  retry_d  = retry_q + 3'd1;
                  state_d  = BACKOFF;
                  bo_len_d = backoff_len(lfsr_val, retry_q + 3'd1);
               end else begin
                  state_d   = IDLE;
                  done_fail = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bo_len_q   <= '0;
         retry_q    <= 3'd0;
         ack_mode_q <= 1'b0;
         rx_en_q    <= 1'b0;
         tx_en_q    <= 1'b0;
         tx_start_q <= 1'b0;
         busy_q     <= 1'b0;
         tx_ok_q    <= 1'b0;
         tx_fail_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bo_len_q   <= bo_len_d;
         retry_q    <= retry_d;
         ack_mode_q <= ack_mode_d;
         rx_en_q    <= (state_d inside {SETTLE_RX, CCA, BACKOFF, ACK_WAIT}) ||
                       ((state_d == IDLE) && bus.listen_en);
         tx_en_q    <= state_d inside {SETTLE_TX, TX};
         tx_start_q <= (state_d == SETTLE_TX) && (cnt_d == SETTLE_LAST);
         busy_q     <= state_d != IDLE;
         tx_ok_q    <= done_ok;
         tx_fail_q  <= done_fail;
      end
   end

   assign bus.radio_rx_en = rx_en_q;
   assign bus.radio_tx_en = tx_en_q;
   assign bus.tx_start    = tx_start_q;
   assign bus.busy        = busy_q;
   assign bus.tx_ok       = tx_ok_q;
   assign bus.tx_fail     = tx_fail_q;
   assign bus.retry_cnt   = retry_q;

`ifdef MAC_STATS_EN
   logic [15:0] stat_cca_q;
   logic [15:0] stat_fail_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_cca_q  <= 16'd0;
         stat_fail_q <= 16'd0;
      end else begin
         if ((state_q == CCA) && (state_d == BACKOFF) && (stat_cca_q != 16'hFFFF)) begin
            stat_cca_q <= stat_cca_q + 16'd1;
         end
         if (done_fail && (stat_fail_q != 16'hFFFF)) begin
            stat_fail_q <= stat_fail_q + 16'd1;
         end
      end
   end

   assign stat_cca_busy = stat_cca_q;
   assign stat_tx_fail  = stat_fail_q;
`endif

endmodule

// File: tb/tb_radio_mac_ctrl.sv
// Directed bench for radio_mac_ctrl: clean send, busy channel, listen mode,
// ack success/timeout, ignored inputs and reset in the middle of TX.
module tb_radio_mac_ctrl;

   logic clk;
   logic reset;

   radio_mac_if bus ();

`ifdef MAC_STATS_EN
   logic [15:0] stat_cca_busy;
   logic [15:0] stat_tx_fail;
`endif

   radio_mac_ctrl #(.SEED(8'hA5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
`ifdef MAC_STATS_EN
      ,
      .stat_cca_busy (stat_cca_busy),
      .stat_tx_fail  (stat_tx_fail)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;
   int start_cnt = 0;
   int overlap_cnt = 0;

   // Reference LFSR: x^8+x^6+x^5+x^4+1, seed A5, steps every clock out of reset
   logic [7:0] lfsr_m;
   always @(posedge clk or posedge reset) begin
      if (reset) lfsr_m <= 8'hA5;
      else       lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
   end

   always @(negedge clk) begin
      if (bus.tx_start) start_cnt++;
      assert (!(bus.radio_tx_en && bus.radio_rx_en)) else overlap_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Request lasts one cycle (cycle 0); returns in cycle 1
   task automatic send_req(input logic ack);
      bus.tx_req  = 1'b1;
      bus.ack_req = ack;
      step();
      bus.tx_req  = 1'b0;
      bus.ack_req = 1'b0;
   endtask

   task automatic wait_start(input int from, input int budget, output int cyc);
      cyc = from;
      while (!bus.tx_start && cyc < budget) begin
         step();
         cyc++;
      end
   endtask

   task automatic pulse_tx_done();
      bus.tx_done = 1'b1;
      step();
      bus.tx_done = 1'b0;
   endtask

   int cyc;
   int s0;
   int bad_cnt;
   int exp_cyc;
   logic [7:0] lfsr_cap;

   initial begin
      reset            = 1'b1;
      bus.tx_req       = 1'b0;
      bus.ack_req      = 1'b0;
      bus.listen_en    = 1'b0;
      bus.channel_busy = 1'b0;
      bus.tx_done      = 1'b0;
      bus.ack_rcvd     = 1'b0;
      repeat (3) step();

      chk("rst_rx_en",   bus.radio_rx_en, 0);
      chk("rst_tx_en",   bus.radio_tx_en, 0);
      chk("rst_start",   bus.tx_start,    0);
      chk("rst_busy",    bus.busy,        0);
      chk("rst_ok_fail", {bus.tx_ok, bus.tx_fail}, 0);
      chk("rst_retry",   bus.retry_cnt,   0);
      reset = 1'b0;
      repeat (2) step();

      // Clean send: tx_start 96 cycles after tx_req, tx_done 100 later
      s0 = start_cnt;
      send_req(1'b0);
      chk("clean_busy_rise", bus.busy, 1);
      chk("clean_rx_settle", bus.radio_rx_en, 1);
      wait_start(1, 300, cyc);
      chk("clean_start_lat", cyc, 96);
      chk("clean_tx_en", bus.radio_tx_en, 1);
      step();
      chk("clean_start_1cyc", bus.tx_start, 0);
      repeat (99) step();
      pulse_tx_done();
      chk("clean_ok", bus.tx_ok, 1);
      chk("clean_busy_fall", bus.busy, 0);
      chk("clean_retry", bus.retry_cnt, 0);
      chk("clean_tx_en_off", bus.radio_tx_en, 0);
      step();
      chk("clean_ok_pulse", bus.tx_ok, 0);
      chk("clean_starts", start_cnt - s0, 1);
      $display("xfer clean: tx_start at cycle %0d", cyc);
      repeat (3) step();

      // Busy channel at CCA cycle 30 (request cycle 47)
      s0 = start_cnt;
      send_req(1'b0);
      repeat (46) step();
      lfsr_cap = lfsr_m;
      bus.channel_busy = 1'b1;
      step();
      bus.channel_busy = 1'b0;
      chk("bo_rx_en", bus.radio_rx_en, 1);
      chk("bo_tx_en", bus.radio_tx_en, 0);
      exp_cyc = 127 + (32'(lfsr_cap & 8'h03) + 1) * 32;
      wait_start(48, 1000, cyc);
      chk("bo_start_lat", cyc, exp_cyc);
      step();
      pulse_tx_done();
      chk("bo_ok", bus.tx_ok, 1);
      chk("bo_starts", start_cnt - s0, 1);
      $display("xfer busy-channel: lfsr=%02h tx_start at cycle %0d", lfsr_cap, cyc);
      repeat (3) step();

      // Listen mode: receiver already on, settle skipped
      bus.listen_en = 1'b1;
      step();
      step();
      chk("listen_idle_rx", bus.radio_rx_en, 1);
      send_req(1'b0);
      wait_start(1, 300, cyc);
      chk("listen_start_lat", cyc, 80);
      step();
      pulse_tx_done();
      chk("listen_ok", bus.tx_ok, 1);
      chk("listen_rx_back", bus.radio_rx_en, 1);
      bus.listen_en = 1'b0;
      repeat (2) step();
      chk("listen_rx_off", bus.radio_rx_en, 0);
      $display("xfer listen: tx_start at cycle %0d", cyc);

      // Ack success: ack 500 cycles after tx_done
      send_req(1'b1);
      wait_start(1, 300, cyc);
      repeat (3) step();
      pulse_tx_done();
      chk("ack_wait_busy", bus.busy, 1);
      bad_cnt = 0;
      for (int i = 0; i < 499; i++) begin
         if (!bus.radio_rx_en || bus.radio_tx_en || bus.tx_ok) bad_cnt++;
         step();
      end
      if (!bus.radio_rx_en) bad_cnt++;
      chk("ack_rx_window", bad_cnt, 0);
      bus.ack_rcvd = 1'b1;
      step();
      bus.ack_rcvd = 1'b0;
      chk("ack_ok", bus.tx_ok, 1);
      chk("ack_busy_fall", bus.busy, 0);
      chk("ack_retry", bus.retry_cnt, 0);
      $display("xfer ack-ok: tx_start at cycle %0d", cyc);
      repeat (3) step();

      // Ack timeout: four attempts then tx_fail
      s0 = start_cnt;
      send_req(1'b1);
      cyc = 0;
      while (!bus.tx_fail && !bus.tx_ok && cyc < 40000) begin
         if (bus.tx_start) begin
            step();
            pulse_tx_done();
            cyc += 2;
         end else begin
            step();
            cyc++;
         end
      end
      chk("to_fail", bus.tx_fail, 1);
      chk("to_no_ok", bus.tx_ok, 0);
      chk("to_starts", start_cnt - s0, 4);
      chk("to_retry", bus.retry_cnt, 3);
      chk("to_busy_fall", bus.busy, 0);
      step();
      chk("to_fail_pulse", bus.tx_fail, 0);
      chk("to_retry_hold", bus.retry_cnt, 3);
      $display("xfer ack-timeout: finished after %0d cycles", cyc);
      repeat (3) step();

      // Ignored inputs while busy; ack on the timeout cycle is a success
      s0 = start_cnt;
      send_req(1'b1);
      repeat (30) step();
      bus.tx_req   = 1'b1;
      bus.tx_done  = 1'b1;
      bus.ack_rcvd = 1'b1;
      step();
      bus.tx_req   = 1'b0;
      bus.tx_done  = 1'b0;
      bus.ack_rcvd = 1'b0;
      wait_start(32, 300, cyc);
      chk("ign_start_lat", cyc, 96);
      step();
      pulse_tx_done();
      repeat (4095) step();
      chk("ign_busy_at_to", bus.busy, 1);
      bus.ack_rcvd = 1'b1;
      step();
      bus.ack_rcvd = 1'b0;
      chk("ign_ok", bus.tx_ok, 1);
      chk("ign_no_fail", bus.tx_fail, 0);
      chk("ign_retry", bus.retry_cnt, 0);
      bad_cnt = 0;
      for (int i = 0; i < 300; i++) begin
         step();
         if (bus.busy) bad_cnt++;
      end
      chk("ign_stays_idle", bad_cnt, 0);
      chk("ign_starts", start_cnt - s0, 1);
      $display("xfer collide: ack on timeout cycle accepted");

      // Reset in TX: enables drop asynchronously, next send is normal
      send_req(1'b0);
      wait_start(1, 300, cyc);
      repeat (5) step();
      chk("rtx_tx_en", bus.radio_tx_en, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("rtx_tx_drop", bus.radio_tx_en, 0);
      chk("rtx_rx_drop", bus.radio_rx_en, 0);
      chk("rtx_busy", bus.busy, 0);
      step();
      reset = 1'b0;
      step();
      s0 = start_cnt;
      send_req(1'b0);
      wait_start(1, 300, cyc);
      chk("rtx_start_lat", cyc, 96);
      step();
      pulse_tx_done();
      chk("rtx_ok", bus.tx_ok, 1);
      chk("rtx_starts", start_cnt - s0, 1);
      $display("xfer after-reset: tx_start at cycle %0d", cyc);

      chk("enables_exclusive", overlap_cnt, 0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
